pdiv_unit: RTL
==============

# pdiv_unit

Parametrised iterative integer divider for the EXE stage, the next generation of the fixed 32-bit, 33-cycle divider. Signed or unsigned per operation. Operand width and radix (quotient bits per cycle) are configurable. Valid/ready handshakes on input and output, with a registered result buffer that holds under backpressure. A synchronous cancel flushes in-flight work on pipeline squash.

## Interface
- WIDTH, 32, operand/result width; even, ≥4
- STEP, 1, quotient bits retired per cycle; 1, 2 or 4; WIDTH % STEP == 0
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cancel  in  1  synchronous flush; highest priority after reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept this cycle
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned
- dividend_i  in  WIDTH  dividend
- divisor_i  in  WIDTH  divisor
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- quotient_o  out  WIDTH  quotient, truncated toward zero
- remainder_o  out  WIDTH  remainder, same sign as dividend
- div_by_zero_o  out  1  result came from a zero divisor; qualified by out_valid

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE. At reset, all outputs are 0 except in_ready, which is 1.
- in_ready = !cancel && (IDLE || (DONE && out_ready)). Acceptance is in_valid && in_ready.
- Accept:
  - Latch |dividend| and |divisor|: negate when is_signed and the MSB is set.
  - Latch q_neg = is_signed && (dividend MSB ^ divisor MSB), r_neg = is_signed && dividend MSB, and a zero-divisor flag.
  - Load count N = WIDTH/STEP, clear the partial remainder, go to BUSY.
- BUSY:
  - Perform STEP restoring shift-subtract steps per cycle, MSB first, on a WIDTH+1-bit partial remainder.
  - Decrement the count. When the count hits 1, write the sign-corrected quotient/remainder into the output registers and go to DONE.
- DONE:
  - out_valid = 1; outputs stay stable until out_ready.
  - On out_ready with no new acceptance, go to IDLE.
  - On out_ready with a simultaneous acceptance, go straight to BUSY (back-to-back).
- Sign correction: quotient = q_neg ? -q : q; remainder = r_neg ? -r : r (mod 2^WIDTH).
- Zero divisor:
  - The iteration still runs.
  - Final result is forced to quotient = all ones and remainder = original dividend_i bits, regardless of sign mode.
  - div_by_zero_o = 1.
- Signed overflow (MIN / -1): quotient = MIN (wraps), remainder = 0, no flag.
- cancel: next edge goes to IDLE, out_valid = 0, and any held result is discarded. in_ready is 0 during the cancel cycle, so a same-cycle in_valid is dropped.
- Reset asserted mid-operation: immediately IDLE, outputs reset, no result produced.

## Timing
- Latency: acceptance at edge k → out_valid high after edge k+N, where N = WIDTH/STEP (32 for the defaults).
- Throughput: one operation per N cycles with out_ready held high. No idle bubble between back-to-back operations.
- quotient_o, remainder_o and div_by_zero_o are registered; there is no combinational path from inputs to outputs.
- in_ready depends combinationally on out_ready and cancel only.
- Changes on operand inputs after acceptance have no effect.

## Configuration
- PDIV_EARLY_OUT_EN defined: at acceptance, if the divisor is zero or |dividend| < |divisor|, skip BUSY and go to DONE at edge k+1.
  - |dividend| < |divisor| gives quotient 0 and remainder = dividend_i.
  - A zero divisor gives the zero-divisor result above.
- PDIV_EARLY_OUT_EN undefined: every operation takes N cycles. Results are identical; only latency differs.

## Test plan
- WIDTH=32, STEP=1, unsigned 100/7 → quotient 14, remainder 2, out_valid exactly 32 cycles after acceptance.
- Signed: -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, div_by_zero_o = 0.
- Unsigned 0x12345678 / 0 → quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero_o = 1. Latency is 1 cycle with PDIV_EARLY_OUT_EN and 32 without.
- Backpressure: out_ready low for 5 cycles after out_valid → outputs stable and in_ready = 0. Then raise out_ready with in_valid high → new op accepted in the same cycle, and its result arrives 32 cycles later.
- cancel at BUSY cycle 10 with in_valid high → no out_valid, in_ready = 0 that cycle, 1 next. A fresh 9/3 then yields quotient 3, remainder 0.
- STEP=4, WIDTH=16, unsigned 0xFFFF/0x0003 → quotient 0x5555, remainder 0, latency 4 cycles. Async rst pulse mid-op → outputs 0 and in_ready = 1 without waiting for a clock edge.

Source files
------------

// File: rtl/pdiv_unit.sv
// pdiv_unit -- iterative restoring integer divider, signed or unsigned per op.
//
// Retires STEP quotient bits per cycle over N = WIDTH/STEP busy cycles.
// Accepted operands are reduced to magnitudes. The signs are applied to the
// final quotient/remainder when they are written into the output registers.
//
// Optional feature macro: PDIV_EARLY_OUT_EN. When defined, a zero divisor or
// |dividend| < |divisor| finishes after a single busy cycle.
//
// Ports:
//   clk, rst                clock (rising edge), async active-low reset
//   cancel                  synchronous flush of in-flight/held work
//   in_valid/in_ready       operand handshake (is_signed, dividend_i, divisor_i)
//   out_valid/out_ready     result handshake (quotient_o, remainder_o,
//                           div_by_zero_o), result held until taken
module pdiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  // quo_r starts as |dividend|: dividend bits shift out at the top while
  // quotient bits shift in at the bottom.
  logic [WIDTH-1:0] quo_r, quo_s;
  // After each restoring step the remainder is below the divisor, so it fits
  // in WIDTH bits. Only the working value needs the extra bit.
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             q_neg_r, q_neg_s, r_neg_r, r_neg_s, dz_r, dz_s;
  logic             early_r, early_s;
  logic [WIDTH-1:0] quotient_r, quotient_s, remainder_r, remainder_s;
  logic             dbz_r, dbz_s;

  logic [WIDTH:0]   work_s;
  logic [WIDTH-1:0] step_q_s, step_r_s;
  logic [WIDTH-1:0] abs_dvd_s, abs_dvs_s;
  logic             dvs_zero_s, accept_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  assign abs_dvd_s  = cond_neg(dividend_i, is_signed & dividend_i[WIDTH-1]);
  assign abs_dvs_s  = cond_neg(divisor_i,  is_signed & divisor_i[WIDTH-1]);
  assign dvs_zero_s = (divisor_i == '0);

  assign in_ready      = !cancel && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s      = in_valid && in_ready;
  assign out_valid     = (state_r == DONE);
  assign quotient_o    = quotient_r;
  assign remainder_o   = remainder_r;
  assign div_by_zero_o = dbz_r;

  // STEP restoring shift-subtract steps, MSB first.
  always_comb begin
    work_s   = {1'b0, rem_r};
    step_q_s = quo_r;
    for (int i = 0; i < STEP; i++) begin
      work_s   = {work_s[WIDTH-1:0], step_q_s[WIDTH-1]};
      step_q_s = {step_q_s[WIDTH-2:0], 1'b0};
      if (work_s >= {1'b0, dvs_r}) begin
        work_s      = work_s - {1'b0, dvs_r};
        step_q_s[0] = 1'b1;
      end else begin
        step_q_s[0] = 1'b0;
      end
    end
    step_r_s = work_s[WIDTH-1:0];
  end

  // Next-state and datapath update; cancel overrides everything but reset.
  always_comb begin
    state_s     = state_r;
    quo_s       = quo_r;
    rem_s       = rem_r;
    dvs_s       = dvs_r;
    cnt_s       = cnt_r;
    q_neg_s     = q_neg_r;
    r_neg_s     = r_neg_r;
    dz_s        = dz_r;
    early_s     = early_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dbz_s       = dbz_r;
    if (cancel) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        BUSY: begin
          quo_s = step_q_s;
          rem_s = step_r_s;
          cnt_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_s = DONE;
            dbz_s   = dz_r;
            // With a zero divisor every step subtracts nothing, so the
            // remainder ends as |dividend|; un-negating restores the original
            // dividend bits. On an early exit, quo_r still holds |dividend|.
            if (dz_r) begin
              quotient_s = '1;
            end else if (early_r) begin
              quotient_s = '0;
            end else begin
              quotient_s = cond_neg(step_q_s, q_neg_r);
            end
            if (early_r) begin
              remainder_s = cond_neg(quo_r, r_neg_r);
            end else begin
              remainder_s = cond_neg(step_r_s, r_neg_r);
            end
          end else begin
            state_s = BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
      // Acceptance covers both IDLE and back-to-back from DONE.
      if (accept_s) begin
        state_s = BUSY;
        quo_s   = abs_dvd_s;
        dvs_s   = abs_dvs_s;
        rem_s   = '0;
        cnt_s   = CW'(N);
        q_neg_s = is_signed & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        r_neg_s = is_signed & dividend_i[WIDTH-1];
        dz_s    = dvs_zero_s;
        early_s = 1'b0;
`ifdef PDIV_EARLY_OUT_EN
        if (dvs_zero_s || (abs_dvd_s < abs_dvs_s)) begin
          early_s = 1'b1;
          cnt_s   = CW'(1);
        end else begin
          early_s = 1'b0;
        end
`endif
      end else begin
        early_s = early_r;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      quo_r       <= '0;
      rem_r       <= '0;
      dvs_r       <= '0;
      cnt_r       <= '0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dz_r        <= 1'b0;
      early_r     <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      quo_r       <= quo_s;
      rem_r       <= rem_s;
      dvs_r       <= dvs_s;
      cnt_r       <= cnt_s;
      q_neg_r     <= q_neg_s;
      r_neg_r     <= r_neg_s;
      dz_r        <= dz_s;
      early_r     <= early_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      dbz_r       <= dbz_s;
    end
  end

endmodule
